// File: rtl/trash_core.sv
// trash_core: load-then-run 16-bit-instruction processor with program RAM,
// register file, data RAM, ALU, branches and a registered output port.
//
// state   | meaning
// S_LOAD  | programming: load_valid writes program[load_ptr]
// S_FETCH | ir <= program[pc]
// S_EXEC  | commit ir, advance or branch pc
// S_HALT  | stopped after HALT, waits for load_en
module trash_core #(
  parameter int DATA_W     = 8,
  parameter int REGS       = 4,
  parameter int PROG_DEPTH = 8,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic                          load_valid,
  input  logic [15:0]                   load_instr,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  output logic                          halted,
  output logic [$clog2(PROG_DEPTH)-1:0] pc
);

  localparam int RW = $clog2(REGS);
  localparam int PW = $clog2(PROG_DEPTH);
  localparam int MW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [15:0]       prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0] data_mem [MEM_DEPTH];
  logic [DATA_W-1:0] regs     [REGS];
  logic [15:0]       ir;
  logic [PW-1:0]     load_ptr;

  logic [3:0]        op, sel;
  logic [7:0]        b;
  logic [RW-1:0]     ra, rx, ry;
  logic [DATA_W-1:0] x, y, va, alu_res;
  logic              commit;
  logic              reg_we, mem_we, jump, out_we;
  logic [RW-1:0]     reg_wa;
  logic [DATA_W-1:0] reg_wd;

  assign op     = ir[15:12];
  assign sel    = ir[11:8];
  assign b      = ir[7:0];
  assign ra     = ir[8 +: RW];
  assign rx     = ir[0 +: RW];
  assign ry     = ir[4 +: RW];
  assign x      = regs[rx];
  assign y      = regs[ry];
  assign va     = regs[ra];
  // Raising load_en during EXEC cancels the instruction in flight.
  assign commit = (state == S_EXEC) && !load_en;
  assign halted = (state == S_HALT);

  always_comb begin
    alu_res = '0;
    case (sel)
      4'h0: alu_res = x + y;
      4'h1: alu_res = x - y;
      4'h2: alu_res = x & y;
      4'h3: alu_res = x | y;
      4'h4: alu_res = x ^ y;
      4'h5: alu_res = ~x;
      4'h6: alu_res = x >> 1;
      4'h7: alu_res = x << 1;
      4'h8: alu_res = x + DATA_W'(1);
      4'h9: alu_res = x - DATA_W'(1);
      4'hA: alu_res = DATA_W'(x == y);
      4'hB: alu_res = DATA_W'(x < y);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    reg_we = 1'b0;
    reg_wa = ra;
    reg_wd = DATA_W'(b);
    mem_we = 1'b0;
    jump   = 1'b0;
    out_we = 1'b0;
    if (commit) begin
      case (op)
        4'h1: reg_we = 1'b1;
        4'h2: begin
          reg_we = 1'b1;
          reg_wa = rx;
          reg_wd = alu_res;
        end
        4'h3: mem_we = 1'b1;
        4'h4: begin
          reg_we = 1'b1;
          reg_wd = data_mem[b[MW-1:0]];
        end
        4'h5: jump   = 1'b1;
        4'h6: jump   = (va == '0);
        4'h7: out_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (!load_en) state_nxt = S_FETCH;
      S_FETCH: state_nxt = load_en ? S_LOAD : S_EXEC;
      S_EXEC: begin
        if (load_en)         state_nxt = S_LOAD;
        else if (op == 4'hF) state_nxt = S_HALT;
        else                 state_nxt = S_FETCH;
      end
      S_HALT:  if (load_en) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      load_ptr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ir        <= '0;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= out_we;
      case (state)
        S_LOAD: begin
          if (!load_en)        pc       <= '0;
          else if (load_valid) load_ptr <= load_ptr + PW'(1);
        end
        S_FETCH: if (!load_en) ir <= prog_mem[pc];
        default: ;
      endcase
      if (state != S_LOAD && load_en) load_ptr <= '0;
      if (commit) pc <= jump ? b[PW-1:0] : pc + PW'(1);
      if (reg_we) regs[reg_wa] <= reg_wd;
      if (out_we) out_data <= va;
    end
  end

  // Program and data RAM keep their contents across reset.
  always_ff @(posedge clk) begin
    if (!reset && state == S_LOAD && load_en && load_valid)
      prog_mem[load_ptr] <= load_instr;
    if (!reset && mem_we)
      data_mem[b[MW-1:0]] <= va;
  end

endmodule

// File: tb/tb_trash_core.sv
// Self-checking bench for trash_core (default parameters): directed programs
// plus random programs checked cycle by cycle against an instruction-level model.
module tb_trash_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_instr = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        halted;
  logic [2:0]  pc;

  trash_core dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_instr (load_instr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .halted     (halted),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instruction-level reference state
  int m_prog [8];
  int m_regs [4];
  int m_mem  [16];
  int m_ptr, m_pc, m_out;
  logic [15:0] ldq [$];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int alu_ref(input int s, input int xv, input int yv);
    case (s)
      0:  return (xv + yv) % 256;
      1:  return (xv - yv + 256) % 256;
      2:  return xv & yv;
      3:  return xv | yv;
      4:  return xv ^ yv;
      5:  return 255 - xv;
      6:  return xv / 2;
      7:  return (xv * 2) % 256;
      8:  return (xv + 1) % 256;
      9:  return (xv + 255) % 256;
      10: return (xv == yv) ? 1 : 0;
      11: return (xv < yv) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(output bit ov, output bit hlt);
    int w, op, a, bb, npc;
    w   = m_prog[m_pc];
    op  = w / 4096;
    a   = (w / 256) % 16;
    bb  = w % 256;
    npc = (m_pc + 1) % 8;
    ov  = 0;
    hlt = 0;
    case (op)
      1:  m_regs[a % 4] = bb;
      2:  m_regs[bb % 4] = alu_ref(a, m_regs[bb % 4], m_regs[(bb / 16) % 4]);
      3:  m_mem[bb % 16] = m_regs[a % 4];
      4:  m_regs[a % 4] = m_mem[bb % 16];
      5:  npc = bb % 8;
      6:  if (m_regs[a % 4] == 0) npc = bb % 8;
      7:  begin m_out = m_regs[a % 4]; ov = 1; end
      15: hlt = 1;
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; load_en = 1'b1; load_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_out = 0; m_ptr = 0; m_pc = 0;
  endtask

  task automatic load_q();
    @(negedge clk);
    load_en = 1'b1; load_valid = 1'b0;
    @(negedge clk);
    foreach (ldq[i]) begin
      load_valid = 1'b1;
      load_instr = ldq[i];
      m_prog[m_ptr] = int'(ldq[i]);
      m_ptr = (m_ptr + 1) % 8;
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  // abort_at: edge index (after load_en falls) at which load_en is raised again
  task automatic run_prog(input int abort_at);
    bit ov, hlt;
    @(negedge clk);
    load_en    = 1'b0;
    load_valid = 1'($urandom_range(0, 1));
    load_instr = 16'($urandom);
    m_pc = 0;
    @(posedge clk); #1;
    check("pc_start", pc, 0);
    check("halted_start", halted, 0);
    for (int c = 1; c < 1000; c++) begin
      if (c == abort_at) begin
        @(negedge clk);
        load_en = 1'b1; load_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_halted", halted, 0);
        m_ptr = 0;
        return;
      end
      @(posedge clk); #1;
      if (c % 2 == 0) begin
        model_step(ov, hlt);
        check("out_valid", out_valid, int'(ov));
        check("out_data", out_data, m_out);
        check("halted", halted, int'(hlt));
        if (hlt) begin
          @(posedge clk); #1;
          check("halt_hold", halted, 1);
          check("halt_out_valid", out_valid, 0);
          m_ptr = 0;
          return;
        end
        check("pc_exec", pc, m_pc);
      end else begin
        check("out_valid_fetch", out_valid, 0);
        check("pc_fetch", pc, m_pc);
      end
    end
    check("run_bound_expired", 0, 1);
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 15);
    case (r)
      0:        op = 4'h0;
      1, 2:     op = 4'h1;
      3, 4:     op = 4'h2;
      5:        op = 4'h3;
      6:        op = 4'h4;
      7:        op = 4'h5;
      8, 9:     op = 4'h6;
      10, 11:   op = 4'h7;
      12:       op = 4'hF;
      13:       op = 4'h9;
      default:  op = 4'h2;
    endcase
    return {op, 12'($urandom)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    for (int i = 0; i < 8; i++) m_prog[i] = 0;
    do_reset();

    // Clear data RAM with ST r0 (r0 = 0 after reset)
    for (int k = 0; k < 16; k += 7) begin
      ldq = {};
      for (int j = 0; j < 7; j++) ldq.push_back(16'h3000 | 16'((k + j) % 16));
      ldq.push_back(16'hF000);
      load_q();
      run_prog(100);
    end

    // LDI/OUT/HALT
    ldq = {16'h112A, 16'h7100, 16'hF000};
    load_q();
    run_prog(100);
    check("t1_out_data", out_data, 'h2A);

    // ALU add wraps
    ldq = {16'h10FF, 16'h1101, 16'h2010, 16'h7000, 16'hF000};
    load_q();
    run_prog(100);
    check("t2_wrap", out_data, 'h00);

    // Count-down loop: 2,1,0 then halt
    ldq = {16'h1003, 16'h2900, 16'h7000, 16'h6006, 16'h5001, 16'hF000, 16'hF000};
    load_q();
    run_prog(100);
    check("t3_last_out", out_data, 0);

    // Store / load round trip, then aliased address 21 -> 5
    ldq = {16'h125C, 16'h3205, 16'h1200, 16'h4215, 16'h7200, 16'hF000};
    load_q();
    run_prog(100);
    check("t4_alias", out_data, 'h5C);

    // Nine words: the ninth overwrites program[0]
    ldq = {16'h1111, 16'h7100, 16'hF000, 16'h0000, 16'h0000, 16'h0000,
           16'h0000, 16'h0000, 16'h1166};
    load_q();
    run_prog(100);
    check("t5_wrap_load", out_data, 'h66);

    // load_en rises with an OUT in EXEC: not committed
    ldq = {16'h7100, 16'h7100};
    load_q();
    run_prog(2);

    // Reset during EXEC of OUT, then a single word lands at program[0]
    ldq = {16'h112A, 16'h7100, 16'hF000};
    load_q();
    @(negedge clk);
    load_en = 1'b0;
    repeat (4) @(posedge clk);
    do_reset();
    ldq = {16'h1133};
    load_q();
    run_prog(100);
    check("t6_reset_exec", out_data, 'h33);

    // Reset during LOAD restarts the load pointer
    ldq = {16'h1177, 16'h7100};
    load_q();
    do_reset();
    ldq = {16'h1144};
    load_q();
    run_prog(100);
    check("t6_reset_load", out_data, 'h44);

    // Random programs with random abort points
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(8, 11);
      ldq = {};
      for (int j = 0; j < n; j++) ldq.push_back(rand_word());
      load_q();
      run_prog($urandom_range(3, 60));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
